// File: rtl/uc_rr_arbiter.sv
// Unit-clause arbiter: memory-first, round-robin or sticky-scan over engine queues,
// with dedup/conflict checking and a registered broadcast port. Optional counters: UC_ARB_STATS_EN.
module uc_rr_arbiter #(
    parameter int NUM_ENG = 4,
    parameter int VAR_MAX = 255,
    parameter int LIT_W   = $clog2(VAR_MAX + 1) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     mem_valid,
    input  logic [LIT_W-1:0]         mem_lit,
    output logic                     mem_ready,
    input  logic [NUM_ENG-1:0]       eng_valid,
    input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
    output logic [NUM_ENG-1:0]       eng_pop,
    output logic                     out_valid,
    output logic [LIT_W-1:0]         out_lit,
    input  logic                     out_ready,
    output logic                     conflict,
    output logic [LIT_W-2:0]         conflict_var,
    output logic                     busy,
    output logic [15:0]              stat_grants,
    output logic [15:0]              stat_drops
);

    localparam int PTR_W = $clog2(NUM_ENG);
    localparam int VAR_W = LIT_W - 1;

    localparam logic [1:0] ST_UNASSIGNED = 2'd0;
    localparam logic [1:0] ST_POS        = 2'd1;
    localparam logic [1:0] ST_NEG        = 2'd2;

    // Entry 0 is never written; it exists so the table can be indexed by the raw variable.
    logic [1:0]       asg_q [0:VAR_MAX];
    logic [1:0]       asg_d [0:VAR_MAX];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [LIT_W-1:0] out_lit_q, out_lit_d;
    logic             conflict_q, conflict_d;
    logic [VAR_W-1:0] conflict_var_q, conflict_var_d;

    logic             can_take;
    logic             mem_grant;
    logic             eng_found;
    int               eng_sel;
    int               scan_idx;
    logic             gnt_any;
    logic [LIT_W-1:0] gnt_lit;
    logic             lit_neg;
    logic [LIT_W-1:0] lit_mag;
    logic [VAR_W-1:0] gnt_var;
    logic             var_ok;
    logic [1:0]       cur_state;
    logic [1:0]       lit_pol;
    logic             is_new;
    logic             is_dup;
    logic             is_conf;

    // Arbitration: memory wins outright; engines share the remaining slot.
    always_comb begin
        can_take  = rst && !conflict_q && !clear && (!out_valid_q || out_ready);
        mem_grant = can_take && mem_valid;
        eng_found = 1'b0;
        eng_sel   = 0;
        scan_idx  = 0;
        ptr_d     = ptr_q;

        if (can_take && !mem_valid) begin
            if (mode) begin
                // Walk downward so the last hit is the nearest engine at or after ptr.
                for (int i = NUM_ENG - 1; i >= 0; i--) begin
                    scan_idx = (int'(ptr_q) + i) % NUM_ENG;
                    if (eng_valid[scan_idx]) begin
                        eng_found = 1'b1;
                        eng_sel   = scan_idx;
                    end
                end
                if (eng_found) begin
                    ptr_d = PTR_W'((eng_sel + 1) % NUM_ENG);
                end
            end else begin
                if (eng_valid[ptr_q]) begin
                    eng_found = 1'b1;
                    eng_sel   = int'(ptr_q);
                end else begin
                    ptr_d = PTR_W'((int'(ptr_q) + 1) % NUM_ENG);
                end
            end
        end

        if (clear) begin
            ptr_d = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            eng_pop[i] = eng_found && (eng_sel == i);
        end
    end

    assign mem_ready = mem_grant;
    assign gnt_any   = mem_grant || eng_found;
    assign gnt_lit   = mem_grant ? mem_lit : eng_lit[eng_sel*LIT_W +: LIT_W];

    // Magnitude of the most negative literal overflows the variable field; it is treated as invalid.
    always_comb begin
        lit_neg   = gnt_lit[LIT_W-1];
        lit_mag   = lit_neg ? (~gnt_lit + 1'b1) : gnt_lit;
        gnt_var   = lit_mag[VAR_W-1:0];
        var_ok    = !lit_mag[LIT_W-1] && (gnt_var != '0) && (int'(gnt_var) <= VAR_MAX);
        cur_state = var_ok ? asg_q[gnt_var] : ST_UNASSIGNED;
        lit_pol   = lit_neg ? ST_NEG : ST_POS;
        is_new    = gnt_any && var_ok && (cur_state == ST_UNASSIGNED);
        is_dup    = gnt_any && var_ok && (cur_state == lit_pol);
        is_conf   = gnt_any && var_ok && (cur_state != ST_UNASSIGNED) && (cur_state != lit_pol);
    end

    always_comb begin
        asg_d          = asg_q;
        out_valid_d    = out_valid_q;
        out_lit_d      = out_lit_q;
        conflict_d     = conflict_q;
        conflict_var_d = conflict_var_q;

        if (clear) begin
            for (int v = 0; v <= VAR_MAX; v++) begin
                asg_d[v] = ST_UNASSIGNED;
            end
            out_valid_d    = 1'b0;
            out_lit_d      = '0;
            conflict_d     = 1'b0;
            conflict_var_d = '0;
        end else begin
            if (is_new) begin
                asg_d[gnt_var] = lit_pol;
            end
            if (is_conf) begin
                conflict_d     = 1'b1;
                conflict_var_d = gnt_var;
            end
            if (out_valid_q && !out_ready) begin
                out_valid_d = 1'b1;
            end else if (is_new) begin
                out_valid_d = 1'b1;
                out_lit_d   = gnt_lit;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v <= VAR_MAX; v++) begin
                asg_q[v] <= ST_UNASSIGNED;
            end
            ptr_q          <= '0;
            out_valid_q    <= 1'b0;
            out_lit_q      <= '0;
            conflict_q     <= 1'b0;
            conflict_var_q <= '0;
        end else begin
            asg_q          <= asg_d;
            ptr_q          <= ptr_d;
            out_valid_q    <= out_valid_d;
            out_lit_q      <= out_lit_d;
            conflict_q     <= conflict_d;
            conflict_var_q <= conflict_var_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_lit      = out_lit_q;
    assign conflict     = conflict_q;
    assign conflict_var = conflict_var_q;
    assign busy         = out_valid_q || mem_valid || (|eng_valid);

`ifdef UC_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_drops_q, stat_drops_d;

    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_drops_d  = stat_drops_q;
        if (clear) begin
            stat_grants_d = '0;
            stat_drops_d  = '0;
        end else begin
            if (is_new && (stat_grants_q != 16'hFFFF)) begin
                stat_grants_d = stat_grants_q + 16'd1;
            end
            if (is_dup && (stat_drops_q != 16'hFFFF)) begin
                stat_drops_d = stat_drops_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants_q <= '0;
            stat_drops_q  <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_drops_q  <= stat_drops_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_drops  = stat_drops_q;
`else
    assign stat_grants = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_uc_rr_arbiter.sv
// Scenario bench for uc_rr_arbiter: expected broadcast literals are queued at stimulus time
// and matched by a monitor at each output handshake.
module tb_uc_rr_arbiter;

    localparam int NUM_ENG = 4;
    localparam int VAR_MAX = 255;
    localparam int LIT_W   = 9;

    logic                     clk;
    logic                     rst;
    logic                     clear;
    logic                     mode;
    logic                     mem_valid;
    logic [LIT_W-1:0]         mem_lit;
    logic                     mem_ready;
    logic [NUM_ENG-1:0]       eng_valid;
    logic [NUM_ENG*LIT_W-1:0] eng_lit;
    logic [NUM_ENG-1:0]       eng_pop;
    logic                     out_valid;
    logic [LIT_W-1:0]         out_lit;
    logic                     out_ready;
    logic                     conflict;
    logic [LIT_W-2:0]         conflict_var;
    logic                     busy;
    logic [15:0]              stat_grants;
    logic [15:0]              stat_drops;

    int n_cmp = 0;
    int n_bad = 0;
    logic [LIT_W-1:0] sb [$];

    uc_rr_arbiter #(.NUM_ENG(NUM_ENG), .VAR_MAX(VAR_MAX), .LIT_W(LIT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .mode(mode),
        .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_ready(mem_ready),
        .eng_valid(eng_valid), .eng_lit(eng_lit), .eng_pop(eng_pop),
        .out_valid(out_valid), .out_lit(out_lit), .out_ready(out_ready),
        .conflict(conflict), .conflict_var(conflict_var), .busy(busy),
        .stat_grants(stat_grants), .stat_drops(stat_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Output monitor: a handshake completes on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_unexpected: got out_lit=%0d, expected nothing", $signed(out_lit));
            end else begin
                logic [LIT_W-1:0] exp_lit;
                exp_lit = sb.pop_front();
                if (out_lit !== exp_lit) begin
                    n_bad++;
                    $display("FAIL scoreboard_out_lit: got %0d, expected %0d", $signed(out_lit), $signed(exp_lit));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input int idx, input int lit);
        eng_lit[idx*LIT_W +: LIT_W] = LIT_W'(lit);
    endtask

    task automatic drain();
        eng_valid = '0;
        mem_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL drain_queue: %0d literals still expected, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0; mode = 1'b1; out_ready = 1'b1;
        mem_valid = 1'b1; mem_lit = LIT_W'(3); eng_valid = 4'b1111; eng_lit = '0;
        repeat (2) tick();
        #2;
        n_cmp++;
        if ({mem_ready, eng_pop} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_grants: got mem_ready=%b eng_pop=%b, required 0", mem_ready, eng_pop);
        end
        n_cmp++;
        if ({out_valid, out_lit, conflict, conflict_var} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b lit=%0d conf=%b var=%0d, required 0",
                     out_valid, out_lit, conflict, conflict_var);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy_inputs: got %b, required 1", busy);
        end
        mem_valid = 1'b0; eng_valid = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy_idle: got %b, required 0", busy);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        mode = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_eng(k, k + 1);
            sb.push_back(LIT_W'(k + 1));
        end
        eng_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_cmp++;
            if (eng_pop !== (4'b0001 << k)) begin
                n_bad++;
                $display("FAIL rr_pop_%0d: got %b, required %b", k, eng_pop, 4'b0001 << k);
            end
            tick();
            eng_valid[k] = 1'b0;
        end
        // Pointer must be back at 0: engine 0 wins over engine 3.
        set_eng(0, 10); set_eng(3, 13);
        eng_valid = 4'b1001;
        sb.push_back(LIT_W'(10)); sb.push_back(LIT_W'(13));
        #2;
        n_cmp++;
        if (eng_pop !== 4'b0001) begin
            n_bad++;
            $display("FAIL rr_wrap_first: got %b, required 0001", eng_pop);
        end
        tick();
        eng_valid = 4'b1000;
        #2;
        n_cmp++;
        if (eng_pop !== 4'b1000) begin
            n_bad++;
            $display("FAIL rr_wrap_second: got %b, required 1000", eng_pop);
        end
        tick();
        drain();
    endtask

    task automatic test_mem_priority();
        mem_valid = 1'b1; mem_lit = LIT_W'(5);
        set_eng(2, 6); eng_valid = 4'b0100;
        sb.push_back(LIT_W'(5)); sb.push_back(LIT_W'(6));
        #2;
        n_cmp++;
        if ({mem_ready, eng_pop} !== 5'b10000) begin
            n_bad++;
            $display("FAIL mem_first: got mem_ready=%b eng_pop=%b, required 1/0000", mem_ready, eng_pop);
        end
        tick();
        mem_valid = 1'b0;
        #2;
        n_cmp++;
        if ({mem_ready, eng_pop} !== 5'b00100) begin
            n_bad++;
            $display("FAIL mem_then_eng: got mem_ready=%b eng_pop=%b, required 0/0100", mem_ready, eng_pop);
        end
        tick();
        drain();
    endtask

    task automatic test_dup_conflict();
        set_eng(0, 7); eng_valid = 4'b0001;
        sb.push_back(LIT_W'(7));
        tick();
        #2;
        n_cmp++;
        if (eng_pop !== 4'b0001) begin
            n_bad++;
            $display("FAIL dup_pop: got %b, required 0001", eng_pop);
        end
        tick();
        set_eng(0, -7);
        #2;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dup_dropped: got out_valid=%b, required 0", out_valid);
        end
        tick();
        set_eng(0, 8);
        #2;
        n_cmp++;
        if ({conflict, conflict_var} !== {1'b1, 8'd7}) begin
            n_bad++;
            $display("FAIL conflict_flag: got conf=%b var=%0d, required 1/7", conflict, conflict_var);
        end
        repeat (2) begin
            n_cmp++;
            if (eng_pop !== 4'b0000) begin
                n_bad++;
                $display("FAIL conflict_blocks: got eng_pop=%b, required 0000", eng_pop);
            end
            tick();
            #2;
        end
        clear = 1'b1;
        #1;
        n_cmp++;
        if (eng_pop !== 4'b0000) begin
            n_bad++;
            $display("FAIL clear_beats_grant: got eng_pop=%b, required 0000", eng_pop);
        end
        tick();
        clear = 1'b0;
        sb.push_back(LIT_W'(8));
        #2;
        n_cmp++;
        if ({conflict, eng_pop} !== 5'b00001) begin
            n_bad++;
            $display("FAIL after_clear: got conf=%b eng_pop=%b, required 0/0001", conflict, eng_pop);
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_eng(0, 9); eng_valid = 4'b0001;
        sb.push_back(LIT_W'(9));
        tick();
        set_eng(0, 20);
        for (int c = 0; c < 3; c++) begin
            #2;
            n_cmp++;
            if ({out_valid, out_lit, eng_pop} !== {1'b1, 9'd9, 4'b0000}) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got valid=%b lit=%0d pop=%b, required 1/9/0000",
                         c, out_valid, $signed(out_lit), eng_pop);
            end
            tick();
        end
        out_ready = 1'b1;
        sb.push_back(LIT_W'(20));
        #2;
        n_cmp++;
        if (eng_pop !== 4'b0001) begin
            n_bad++;
            $display("FAIL stall_release_pop: got %b, required 0001", eng_pop);
        end
        tick();
        eng_valid = '0;
        #2;
        n_cmp++;
        if ({out_valid, out_lit} !== {1'b1, 9'd20}) begin
            n_bad++;
            $display("FAIL stall_reload: got valid=%b lit=%0d, required 1/20", out_valid, $signed(out_lit));
        end
        tick();
        drain();
    endtask

    task automatic test_sticky_scan();
        clear = 1'b1; mode = 1'b0;
        tick();
        clear = 1'b0;
        set_eng(2, 30); eng_valid = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_cmp++;
            if (eng_pop !== 4'b0000) begin
                n_bad++;
                $display("FAIL scan_step_%0d: got %b, required 0000", c, eng_pop);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            set_eng(2, 30 + c);
            sb.push_back(LIT_W'(30 + c));
            #2;
            n_cmp++;
            if (eng_pop !== 4'b0100) begin
                n_bad++;
                $display("FAIL scan_sticky_%0d: got %b, required 0100", c, eng_pop);
            end
            tick();
        end
        drain();
        mode = 1'b1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        set_eng(0, 40); eng_valid = 4'b0001;
        tick();
        eng_valid = '0;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_lit} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_out: got valid=%b lit=%0d, required 0/0", out_valid, $signed(out_lit));
        end
        tick();
        rst = 1'b1; out_ready = 1'b1;
        set_eng(0, 41); eng_valid = 4'b0001;
        sb.push_back(LIT_W'(41));
        tick();
        set_eng(0, -41);
        tick();
        set_eng(0, 43);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({conflict, conflict_var, eng_pop} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_conf: got conf=%b var=%0d pop=%b, required 0", conflict, conflict_var, eng_pop);
        end
        tick();
        rst = 1'b1;
        set_eng(0, 41);
        sb.push_back(LIT_W'(41));
        #2;
        n_cmp++;
        if (eng_pop !== 4'b0001) begin
            n_bad++;
            $display("FAIL post_reset_accept: got %b, required 0001", eng_pop);
        end
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_mem_priority();
        test_dup_conflict();
        test_backpressure();
        test_sticky_scan();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
